// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op codes, access-size helpers,
// store lane steering and the access FSM encoding.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b001011;
  localparam logic [5:0] OP_LH  = 6'b001100;
  localparam logic [5:0] OP_LW  = 6'b001101;
  localparam logic [5:0] OP_LBU = 6'b001110;
  localparam logic [5:0] OP_LHU = 6'b001111;
  localparam logic [5:0] OP_SB  = 6'b010000;
  localparam logic [5:0] OP_SH  = 6'b010001;
  localparam logic [5:0] OP_SW  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_lanes_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic size_t access_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] offset);
    logic ok;
    case (access_size(op))
      SZ_HALF: ok = ~offset[0];
      SZ_WORD: ok = (offset == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Replicate the store value across every lane it could land in; the strobes
  // select which lanes the memory actually writes.
  function automatic store_lanes_t store_steer(input logic [5:0]  op,
                                               input logic [1:0]  offset,
                                               input logic [31:0] data);
    store_lanes_t lanes;
    lanes = '0;
    if (is_store(op)) begin
      case (access_size(op))
        SZ_BYTE: begin
          lanes.wdata = {4{data[7:0]}};
          lanes.wstrb = 4'b0001 << offset;
        end
        SZ_HALF: begin
          lanes.wdata = {2{data[15:0]}};
          lanes.wstrb = 4'b0011 << offset;
        end
        SZ_WORD: begin
          lanes.wdata = data;
          lanes.wstrb = 4'b1111;
        end
        default: lanes = '0;
      endcase
    end
    return lanes;
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Extracts the addressed lane from a read word and sign/zero extends it
// according to the load op.
module load_align_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [5:0]  op,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  // NOTE: result gets a default before the case so no latch is inferred.
  always_comb begin
    result = lane;
    case (op)
      OP_LB:   result = {{24{lane[7]}}, lane[7:0]};
      OP_LH:   result = {{16{lane[15]}}, lane[15:0]};
      OP_LBU:  result = {24'd0, lane[7:0]};
      OP_LHU:  result = {16'd0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues one ready-handshaked data memory access per
// instruction, steers store lanes, extends loads and stalls while busy.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [5:0]            aluSelect,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           storeData,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           loadData,
  output logic                  loadValid,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  busError
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t         state, state_d;
  logic [5:0]     op_q;
  logic [1:0]     off_q;
  logic [CNT_W-1:0] cnt_q;

  logic           mem_op;
  logic           accept;
  logic           timeout_hit;
  store_lanes_t   lanes;
  logic [31:0]    extended;

  assign mem_op = is_mem_op(aluSelect);
  assign accept = valid && mem_op && is_aligned(aluSelect, address[1:0]);
  assign lanes  = store_steer(aluSelect, address[1:0], storeData);

  // The current ACCESS cycle is the TIMEOUT_CYCLES-th one without ready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  load_align_extend u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .op     (op_q),
    .result (extended)
  );

  always_comb begin
    state_d = state;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ready || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      loadData   <= '0;
      loadValid  <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
    end else begin
      loadValid  <= 1'b0;
      misaligned <= 1'b0;
      busError   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= aluSelect;
            off_q     <= address[1:0];
            cnt_q     <= '0;
            mem_read  <= is_load(aluSelect);
            mem_write <= is_store(aluSelect);
            mem_addr  <= {address[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= lanes.wdata;
            mem_wstrb <= lanes.wstrb;
          end else if (valid && mem_op) begin
            misaligned <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wstrb <= '0;
            if (is_load(op_q)) begin
              loadData  <= extended;
              loadValid <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wstrb <= '0;
            busError  <= 1'b1;
            loadData  <= '0;
            loadValid <= is_load(op_q);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level reference model is
// compared against the DUT every cycle, plus literal per-test expectations.
module tb_mem_access_unit;

  localparam int TO = 4;

  localparam logic [5:0] LB  = 6'b001011;
  localparam logic [5:0] LH  = 6'b001100;
  localparam logic [5:0] LW  = 6'b001101;
  localparam logic [5:0] LBU = 6'b001110;
  localparam logic [5:0] LHU = 6'b001111;
  localparam logic [5:0] SB  = 6'b010000;
  localparam logic [5:0] SH  = 6'b010001;
  localparam logic [5:0] SW  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset, valid, mem_ready;
  logic [5:0]  aluSelect;
  logic [31:0] address, storeData, mem_rdata;
  logic        mem_read, mem_write, loadValid, stall, misaligned, busError;
  logic [31:0] mem_addr, mem_wdata, loadData;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .valid(valid), .aluSelect(aluSelect),
    .address(address), .storeData(storeData), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .loadData(loadData), .loadValid(loadValid), .stall(stall),
    .misaligned(misaligned), .busError(busError)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic logic model_is_load(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic logic model_accept(input logic v, input logic [5:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return v && sz != 0 && (int'(a[1:0]) % sz == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input int off, input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * off);
    case (op)
      LB:  begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      LH:  begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      LBU: v = v & 32'hFF;
      LHU: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  logic        m_busy = 0, m_done = 0;
  int          m_wait = 0, m_off = 0;
  logic [5:0]  m_op = '0;
  logic        e_read = 0, e_write = 0, e_lv = 0, e_mis = 0, e_berr = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ldata = '0;
  logic [3:0]  e_wstrb = '0;

  task automatic model_finish();
    m_busy = 0; m_done = 1; e_read = 0; e_write = 0;
  endtask

  task automatic model_step();
    int sz;
    if (reset) begin
      m_busy = 0; m_done = 0; m_wait = 0;
      e_read = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_ldata = '0; e_lv = 0; e_mis = 0; e_berr = 0;
    end else begin
      e_lv = 0; e_mis = 0; e_berr = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        m_wait++;
        if (mem_ready) begin
          model_finish();
          if (model_is_load(m_op)) begin
            e_ldata = model_load(m_op, m_off, mem_rdata);
            e_lv = 1;
          end
        end else if (m_wait == TO) begin
          model_finish();
          e_berr = 1; e_ldata = '0; e_lv = model_is_load(m_op);
        end
      end else if (valid && size_of(aluSelect) != 0) begin
        if (model_accept(valid, aluSelect, address)) begin
          sz = size_of(aluSelect);
          m_busy = 1; m_wait = 0; m_op = aluSelect; m_off = int'(address[1:0]);
          e_read = model_is_load(aluSelect);
          e_write = !e_read;
          e_addr = address & 32'hFFFF_FFFC;
          if (sz == 1)      e_wdata = (storeData & 32'hFF) * 32'h0101_0101;
          else if (sz == 2) e_wdata = (storeData & 32'hFFFF) * 32'h0001_0001;
          else              e_wdata = storeData;
          e_wstrb = 4'(((1 << sz) - 1) << m_off);
        end else begin
          e_mis = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cmp_stall", 32'(stall), 32'(m_busy || (!m_done && model_accept(valid, aluSelect, address))));
      check("cmp_mem_read", 32'(mem_read), 32'(e_read));
      check("cmp_mem_write", 32'(mem_write), 32'(e_write));
      check("cmp_loadValid", 32'(loadValid), 32'(e_lv));
      check("cmp_misaligned", 32'(misaligned), 32'(e_mis));
      check("cmp_busError", 32'(busError), 32'(e_berr));
      if (e_read || e_write) check("cmp_mem_addr", mem_addr, e_addr);
      if (e_write) begin
        check("cmp_mem_wdata", mem_wdata, e_wdata);
        check("cmp_mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      end
      if (e_lv) check("cmp_loadData", loadData, e_ldata);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int          stall_cnt;
    logic        fin;
    logic        lv, mis, berr, rd, wr, rd_end, wr_end;
    logic [31:0] ld, addr, wdata;
    logic [3:0]  wstrb;
  } res_t;

  // Issues one op; mem_ready is raised in ACCESS cycle (delay+1), never if delay<0.
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int delay, output res_t r);
    r.stall_cnt = 0; r.fin = 0; r.lv = 0; r.mis = 0; r.berr = 0;
    r.rd = 0; r.wr = 0; r.rd_end = 0; r.wr_end = 0;
    r.ld = '0; r.addr = '0; r.wdata = '0; r.wstrb = '0;
    @(posedge clk); #1;
    valid = 1; aluSelect = op; address = addr; storeData = sd;
    mem_rdata = rd; mem_ready = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) r.stall_cnt++;
      if (c == 1) begin
        r.rd = mem_read; r.wr = mem_write; r.addr = mem_addr;
        r.wdata = mem_wdata; r.wstrb = mem_wstrb;
      end
      if (c >= 1 && !stall) begin
        r.lv = loadValid; r.ld = loadData; r.mis = misaligned; r.berr = busError;
        r.rd_end = mem_read; r.wr_end = mem_write; r.fin = 1;
        break;
      end
      @(posedge clk); #1;
      valid = 0; aluSelect = 6'b000000;
      mem_ready = (c == delay);
    end
    mem_ready = 0;
    if (!r.fin) check("access_completion_bound", 32'd0, 32'd1);
  endtask

  res_t r;

  initial begin
    reset = 1; valid = 0; aluSelect = '0; address = '0; storeData = '0;
    mem_rdata = '0; mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_loadData", loadData, 32'd0);
    check("rst_pulses", {29'd0, loadValid, misaligned, busError}, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 0; cmp_en = 1;

    do_access(LW, 32'h0000_1010, 32'd0, 32'hDEAD_BEEF, 0, r);
    check("lw_stall_cycles", r.stall_cnt, 2);
    check("lw_mem_read", 32'(r.rd), 32'd1);
    check("lw_mem_addr", r.addr, 32'h0000_1010);
    check("lw_loadValid", 32'(r.lv), 32'd1);
    check("lw_loadData", r.ld, 32'hDEAD_BEEF);

    do_access(LB, 32'h0000_1013, 32'd0, 32'h80FF_0000, 0, r);
    check("lb_loadData", r.ld, 32'hFFFF_FF80);
    do_access(LBU, 32'h0000_1013, 32'd0, 32'h80FF_0000, 0, r);
    check("lbu_loadData", r.ld, 32'h0000_0080);

    do_access(SH, 32'h0000_1012, 32'h1234_ABCD, 32'd0, 0, r);
    check("sh_mem_write", 32'(r.wr), 32'd1);
    check("sh_mem_wdata", r.wdata, 32'hABCD_ABCD);
    check("sh_mem_wstrb", 32'(r.wstrb), 32'b1100);
    check("sh_mem_addr", r.addr, 32'h0000_1010);
    check("sh_no_loadValid", 32'(r.lv), 32'd0);

    do_access(SB, 32'h0000_2003, 32'h0000_00A5, 32'd0, 1, r);
    check("sb_mem_wdata", r.wdata, 32'hA5A5_A5A5);
    check("sb_mem_wstrb", 32'(r.wstrb), 32'b1000);
    check("sb_stall_cycles", r.stall_cnt, 3);

    do_access(LW, 32'h0000_1011, 32'd0, 32'd0, 0, r);
    check("lw_mis_stall", r.stall_cnt, 0);
    check("lw_mis_read", 32'(r.rd), 32'd0);
    check("lw_mis_pulse", 32'(r.mis), 32'd1);
    do_access(SH, 32'h0000_1001, 32'd0, 32'd0, 0, r);
    check("sh_mis_stall", r.stall_cnt, 0);
    check("sh_mis_write", 32'(r.wr), 32'd0);
    check("sh_mis_pulse", 32'(r.mis), 32'd1);
    do_access(6'b011000, 32'h0000_1000, 32'd0, 32'd0, 0, r);
    check("nonmem_stall", r.stall_cnt, 0);
    check("nonmem_req", {30'd0, r.rd, r.wr}, 32'd0);
    check("nonmem_mis", 32'(r.mis), 32'd0);

    do_access(SW, 32'h0000_1000, 32'hCAFE_F00D, 32'd0, -1, r);
    check("sw_to_wdata", r.wdata, 32'hCAFE_F00D);
    check("sw_to_wstrb", 32'(r.wstrb), 32'b1111);
    check("sw_to_stall_cycles", r.stall_cnt, 1 + TO);
    check("sw_to_busError", 32'(r.berr), 32'd1);
    check("sw_to_write_dropped", 32'(r.wr_end), 32'd0);

    do_access(LH, 32'h0000_2002, 32'd0, 32'h8001_1234, 2, r);
    check("lh_loadData", r.ld, 32'hFFFF_8001);
    check("lh_stall_cycles", r.stall_cnt, 4);
    do_access(LHU, 32'h0000_2002, 32'd0, 32'h8001_1234, 2, r);
    check("lhu_loadData", r.ld, 32'h0000_8001);

    do_access(LW, 32'h0000_3000, 32'd0, 32'h0BAD_F00D, TO - 1, r);
    check("lw_lastcycle_busError", 32'(r.berr), 32'd0);
    check("lw_lastcycle_loadData", r.ld, 32'h0BAD_F00D);
    do_access(LB, 32'h0000_3001, 32'd0, 32'hFFFF_FFFF, -1, r);
    check("lb_to_loadValid", 32'(r.lv), 32'd1);
    check("lb_to_loadData", r.ld, 32'd0);
    check("lb_to_read_dropped", 32'(r.rd_end), 32'd0);

    // mem_ready while idle must be ignored
    @(posedge clk); #1;
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_loadValid", 32'(loadValid), 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 0;

    // reset while an access is outstanding
    @(posedge clk); #1;
    valid = 1; aluSelect = LW; address = 32'h0000_1010; mem_ready = 0;
    @(posedge clk); #1;
    valid = 0; aluSelect = '0; reset = 1;
    @(negedge clk);
    check("rstmid_read_before", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    reset = 0; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("rstmid_read_after", 32'(mem_read), 32'd0);
    check("rstmid_stall_after", 32'(stall), 32'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rstmid_no_loadValid", 32'(loadValid), 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 0;

    do_access(LW, 32'h0000_4004, 32'd0, 32'h1357_9BDF, 0, r);
    check("post_rst_loadData", r.ld, 32'h1357_9BDF);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller that sits directly downstream of the load/store address adder.
- Consumes the effective address (rs1 + imm) and the 6-bit aluSelect op code.
- Drives a single-port, ready-handshaked data memory. Performs byte-lane steering and write strobes for stores, and lane extraction with sign/zero extension for loads.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of address and memory address bus.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  EX/MEM register holds a valid instruction.
- aluSelect  input  6  op code: LB=001011, LH=001100, LW=001101, LBU=001110, LHU=001111, SB=010000, SH=010001, SW=010010; all other values are non-memory ops.
- address  input  ADDR_WIDTH  effective byte address from the address adder.
- storeData  input  32  rs2 value for stores.
- mem_read  output  1  read request, registered.
- mem_write  output  1  write request, registered.
- mem_addr  output  ADDR_WIDTH  word-aligned address ({address[ADDR_WIDTH-1:2],2'b00}), registered.
- mem_wdata  output  32  lane-steered store data, registered.
- mem_wstrb  output  4  byte write strobes, registered.
- mem_rdata  input  32  read data; sampled only in the cycle where mem_ready=1.
- mem_ready  input  1  memory completes the current request in this cycle.
- loadData  output  32  extended load result, registered.
- loadValid  output  1  one-cycle pulse; loadData is valid.
- stall  output  1  combinational; freezes IF/ID/EX/MEM registers.
- misaligned  output  1  one-cycle registered pulse on a misaligned access.
- busError  output  1  one-cycle registered pulse on a timeout abort.

Behaviour:
- Reset: state=IDLE; mem_read, mem_write, mem_wstrb, loadValid, misaligned, busError = 0; mem_addr, mem_wdata, loadData = 0; timeout counter = 0.
- A reset asserted mid-access deasserts requests at that edge; any late mem_ready is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE accept condition: valid=1 and aluSelect is a memory op and the access is aligned. On accept:
  - latch op, address[1:0] and request outputs;
  - assert mem_read (loads) or mem_write (stores);
  - go to ACCESS.
- Alignment rule: halfword ops need address[0]=0; word ops need address[1:0]=00; bytes are always aligned.
- Misaligned op in IDLE: no memory request; misaligned=1 on the next cycle; state stays IDLE.
- Non-memory op or valid=0 in IDLE: no action, stall=0.
- ACCESS:
  - Requests are held stable until mem_ready=1.
  - On mem_ready: drop requests; for a load, register the extended data into loadData; go to DONE.
  - The timeout counter increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES with no ready: drop requests, pulse busError, loadData=0, go to DONE.
  - The counter clears on entry to ACCESS.
- DONE:
  - loadValid=1 for a load, including a timed-out load (data 0).
  - stall=0, so the pipeline advances at the end of this cycle.
  - Inputs are ignored so the same op is not re-issued.
  - Next state: IDLE.
- stall = (IDLE and accept condition) or ACCESS.
- Store steering by address[1:0]=a:
  - SB: wdata = storeData[7:0] replicated ×4; wstrb = 0001<<a.
  - SH: wdata = storeData[15:0] replicated ×2; wstrb = 0011<<a.
  - SW: wdata = storeData; wstrb = 1111.
- Load extraction: lane = mem_rdata >> (8*a).
  - LB / LH: sign-extend bit 7 / bit 15.
  - LBU / LHU: zero-extend.
  - LW: unmodified.
- Minimum latency: 3 cycles from accept to DONE, with mem_ready in the first ACCESS cycle.
- mem_ready outside ACCESS has no effect.

Decomposition:
- Shared package mem_pkg:
  - op code localparams (OP_LB..OP_SW);
  - is_load / is_store / access-size helper functions;
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
- The same op codes are used by the address adder and the decoder.
- One sub-module: load_align_extend, combinational; inputs rdata, byte offset, op; output 32-bit extended result.

Test Plan:
- LW, address=0x00001010, mem_ready on first ACCESS cycle, rdata=0xDEADBEEF:
  - mem_read=1, mem_addr=0x00001010, stall=1 for 2 cycles;
  - loadValid pulse with loadData=0xDEADBEEF.
- LB, address=0x00001013, rdata=0x80FF_0000:
  - loadData=0xFFFFFF80.
  - Repeat with LBU → 0x00000080.
- SH, address=0x00001012, storeData=0x1234ABCD:
  - mem_write=1, mem_wdata=0xABCDABCD, mem_wstrb=1100, mem_addr=0x00001010.
- Misaligned checks:
  - LW at 0x00001011 → no mem_read, misaligned pulse, stall=0.
  - SH at 0x00001001 → same response.
  - aluSelect=011000 → no request, no stall.
- SW at 0x00001000, mem_ready held low:
  - requests stable;
  - with TIMEOUT_CYCLES=4, mem_write drops and busError pulses after 4 ACCESS cycles.
- Reset mid-access: LW in ACCESS, reset=1 for one cycle:
  - mem_read=0 and state IDLE after the edge;
  - subsequent mem_ready produces no loadValid.
